fft_band_energy: RTL and testbench

//  Per-frame loudness for NBANDS frequency bands, computed from a streaming FFT output.

---
 rtl/fft_energy_pkg.sv | 24 ++
 rtl/fft_mag_sq_pipe.sv | 73 +++++++
 rtl/fft_band_energy.sv | 185 ++++++++++++++++++
 tb/tb_fft_band_energy.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_energy_pkg.sv
// Shared types, default widths and helpers for the FFT band-energy block.
package fft_energy_pkg;

  localparam int unsigned W_DEF      = 16;
  localparam int unsigned NBANDS_DEF = 4;
  localparam int unsigned NFFT_DEF   = 1024;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCUM  = 2'd1;
  localparam state_t DRAIN  = 2'd2;
  localparam state_t OUTPUT = 2'd3;

  // Unsigned add clamped to 2^width-1; operands zero-extended to 64 bits by the caller.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/fft_mag_sq_pipe.sv
// Two-stage |X|^2 pipeline: S1 squares re/im, S2 sums them and resolves the band.
module fft_mag_sq_pipe
  import fft_energy_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned NBANDS = NBANDS_DEF,
  parameter int unsigned BIN_W  = $clog2(NFFT_DEF),
  parameter int unsigned BAND_W = (NBANDS > 1) ? $clog2(NBANDS) : 1,
  localparam int unsigned MAG_W = 2 * W + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic signed [W-1:0]          in_real,
  input  logic signed [W-1:0]          in_imag,
  input  logic [BIN_W-1:0]             in_bin,
  input  logic [(NBANDS+1)*BIN_W-1:0]  edges,
  output logic                         s2_valid,
  output logic [MAG_W-1:0]             s2_mag,
  output logic [BAND_W-1:0]            s2_band,
  output logic                         s2_hit
);

  logic signed [2*W-1:0] re2_c;
  logic signed [2*W-1:0] im2_c;
  logic                  s1_valid;
  logic [2*W-1:0]        s1_re2;
  logic [2*W-1:0]        s1_im2;
  logic [BIN_W-1:0]      s1_bin;
  logic [BAND_W-1:0]     band_c;
  logic                  hit_c;

  assign re2_c = (2*W)'(in_real) * (2*W)'(in_real);
  assign im2_c = (2*W)'(in_imag) * (2*W)'(in_imag);

  // Descending scan so the lowest matching band wins on overlapping edges.
  always_comb begin
    band_c = '0;
    hit_c  = 1'b0;
    for (int b = NBANDS - 1; b >= 0; b--) begin
      if (s1_bin >= edges[b*BIN_W +: BIN_W] && s1_bin < edges[(b+1)*BIN_W +: BIN_W]) begin
        band_c = BAND_W'(b);
        hit_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_re2   <= '0;
      s1_im2   <= '0;
      s1_bin   <= '0;
      s2_valid <= 1'b0;
      s2_mag   <= '0;
      s2_band  <= '0;
      s2_hit   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_re2 <= re2_c;
        s1_im2 <= im2_c;
        s1_bin <= in_bin;
      end
      s2_valid <= s1_valid & ~flush;
      s2_mag   <= MAG_W'(s1_re2) + MAG_W'(s1_im2);
      s2_band  <= band_c;
      s2_hit   <= hit_c;
    end
  end

endmodule

// File: rtl/fft_band_energy.sv
// Per-frame band energy from a streaming FFT; optional peak tracking under FFT_BAND_PEAK_EN.
module fft_band_energy
  import fft_energy_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned NBANDS = NBANDS_DEF,
  parameter int unsigned NFFT   = NFFT_DEF,
  localparam int unsigned BIN_W = $clog2(NFFT),
  localparam int unsigned MAG_W = 2 * W + 1,
  localparam int unsigned ACC_W = 2 * W + 1 + BIN_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fft_valid,
  input  logic                         fft_sop,
  input  logic                         fft_eop,
  input  logic signed [W-1:0]          fft_real,
  input  logic signed [W-1:0]          fft_imag,
  input  logic [(NBANDS+1)*BIN_W-1:0]  band_edge,
  output logic [NBANDS*ACC_W-1:0]      band_energy,
  output logic                         energy_valid,
  output logic                         frame_err
`ifdef FFT_BAND_PEAK_EN
  ,
  output logic [BIN_W-1:0]             peak_bin,
  output logic [MAG_W-1:0]             peak_mag
`endif
);

  localparam int unsigned BAND_W   = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NFFT - 1);

  state_t                      state, state_n;
  logic [BIN_W-1:0]            bin_cnt, bin_cnt_n, bin_idx_c;
  logic [1:0]                  drain_cnt, drain_cnt_n;
  logic                        accept_c, start_c, err_c, publish_c;
  logic [(NBANDS+1)*BIN_W-1:0] edge_q;
  logic                        s2_valid, s2_hit;
  logic [MAG_W-1:0]            s2_mag;
  logic [BAND_W-1:0]           s2_band;
  logic [ACC_W-1:0]            acc [NBANDS];

  fft_mag_sq_pipe #(
    .W      (W),
    .NBANDS (NBANDS),
    .BIN_W  (BIN_W),
    .BAND_W (BAND_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush    (start_c),
    .in_valid (accept_c),
    .in_real  (fft_real),
    .in_imag  (fft_imag),
    .in_bin   (bin_idx_c),
    .edges    (edge_q),
    .s2_valid (s2_valid),
    .s2_mag   (s2_mag),
    .s2_band  (s2_band),
    .s2_hit   (s2_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      bin_cnt   <= bin_cnt_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  // A start (first or restarting sop) clears accumulators and flushes in-flight bins.
  always_comb begin
    state_n     = state;
    bin_cnt_n   = bin_cnt;
    drain_cnt_n = drain_cnt;
    bin_idx_c   = bin_cnt;
    accept_c    = 1'b0;
    start_c     = 1'b0;
    err_c       = 1'b0;
    publish_c   = 1'b0;
    case (state)
      IDLE: begin
        if (fft_valid && fft_sop) begin
          accept_c    = 1'b1;
          start_c     = 1'b1;
          bin_idx_c   = '0;
          bin_cnt_n   = BIN_W'(1);
          drain_cnt_n = '0;
          state_n     = fft_eop ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (fft_valid) begin
          accept_c    = 1'b1;
          drain_cnt_n = '0;
          if (fft_sop) begin
            start_c   = 1'b1;
            err_c     = 1'b1;
            bin_idx_c = '0;
            bin_cnt_n = BIN_W'(1);
            if (fft_eop) state_n = DRAIN;
          end else begin
            bin_cnt_n = bin_cnt + BIN_W'(1);
            if (fft_eop) begin
              state_n = DRAIN;
            end else if (bin_cnt == LAST_BIN) begin
              err_c   = 1'b1;
              state_n = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd2) begin
          publish_c = 1'b1;
          state_n   = OUTPUT;
        end else begin
          drain_cnt_n = drain_cnt + 2'd1;
        end
      end
      OUTPUT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || start_c) begin
      for (int b = 0; b < NBANDS; b++) acc[b] <= '0;
    end else if (s2_valid && s2_hit) begin
      acc[s2_band] <= ACC_W'(sat_add(64'(acc[s2_band]), 64'(s2_mag), ACC_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q       <= '0;
      band_energy  <= '0;
      energy_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      energy_valid <= publish_c;
      frame_err    <= err_c;
      if (start_c) edge_q <= band_edge;
      if (publish_c) begin
        for (int b = 0; b < NBANDS; b++) band_energy[b*ACC_W +: ACC_W] <= acc[b];
      end
    end
  end

`ifdef FFT_BAND_PEAK_EN
  logic [BIN_W-1:0] p1_bin, p2_bin, pk_bin_q;
  logic [MAG_W-1:0] pk_mag_q;

  // Bin index delayed to line up with s2_mag; strict compare keeps the lowest bin on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_bin   <= '0;
      p2_bin   <= '0;
      pk_bin_q <= '0;
      pk_mag_q <= '0;
      peak_bin <= '0;
      peak_mag <= '0;
    end else begin
      if (accept_c) p1_bin <= bin_idx_c;
      p2_bin <= p1_bin;
      if (start_c) begin
        pk_bin_q <= '0;
        pk_mag_q <= '0;
      end else if (s2_valid && s2_mag > pk_mag_q) begin
        pk_bin_q <= p2_bin;
        pk_mag_q <= s2_mag;
      end
      if (publish_c) begin
        peak_bin <= pk_bin_q;
        peak_mag <= pk_mag_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_band_energy.sv
// Scoreboard bench for fft_band_energy; peak checks enabled with FFT_BAND_PEAK_EN.
module tb_fft_band_energy;

  localparam int W     = 16;
  localparam int NB    = 4;
  localparam int NFFT  = 1024;
  localparam int BIN_W = 10;
  localparam int MAG_W = 2 * W + 1;
  localparam int ACC_W = 2 * W + 1 + BIN_W;

  typedef struct packed {
    logic [NB-1:0][ACC_W-1:0] e;
    logic [BIN_W-1:0]         pbin;
    logic [MAG_W-1:0]         pmag;
    logic [31:0]              cyc;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fft_valid = 1'b0, fft_sop = 1'b0, fft_eop = 1'b0;
  logic signed [W-1:0] fft_real = '0, fft_imag = '0;
  logic [(NB+1)*BIN_W-1:0] band_edge = '0;
  logic [NB*ACC_W-1:0] band_energy;
  logic energy_valid, frame_err;
`ifdef FFT_BAND_PEAK_EN
  logic [BIN_W-1:0] peak_bin;
  logic [MAG_W-1:0] peak_mag;
`endif

  fft_band_energy dut (
    .clk          (clk),
    .reset        (reset),
    .fft_valid    (fft_valid),
    .fft_sop      (fft_sop),
    .fft_eop      (fft_eop),
    .fft_real     (fft_real),
    .fft_imag     (fft_imag),
    .band_edge    (band_edge),
    .band_energy  (band_energy),
    .energy_valid (energy_valid),
    .frame_err    (frame_err)
`ifdef FFT_BAND_PEAK_EN
    ,
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0, errors = 0;
  int err_cnt = 0, err_cyc = -1, last_cyc = 0;
  int edge_m [NB+1];
  longint re_m [$];
  longint im_m [$];
  rec_t sb [$];
  rec_t obs_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: snapshots every published result and frame_err pulse.
  always @(posedge clk) begin
    rec_t o;
    #2;
    if (energy_valid === 1'b1) begin
      o.e = band_energy;
`ifdef FFT_BAND_PEAK_EN
      o.pbin = peak_bin;
      o.pmag = peak_mag;
`else
      o.pbin = '0;
      o.pmag = '0;
`endif
      o.cyc = 32'(cyc);
      obs_q.push_back(o);
    end
    if (frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic drive(input bit v, input bit s, input bit e, input int re, input int im);
    @(negedge clk);
    fft_valid = v;
    fft_sop   = s;
    fft_eop   = e;
    fft_real  = W'(re);
    fft_imag  = W'(im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic bin(input bit s, input bit e, input int re, input int im);
    drive(1'b1, s, e, re, im);
    if (s) begin
      re_m.delete();
      im_m.delete();
    end
    re_m.push_back(longint'(re));
    im_m.push_back(longint'(im));
    last_cyc = cyc;
  endtask

  task automatic set_edges(input int e0, input int e1, input int e2, input int e3, input int e4);
    edge_m = '{e0, e1, e2, e3, e4};
    for (int b = 0; b <= NB; b++) band_edge[b*BIN_W +: BIN_W] = BIN_W'(edge_m[b]);
  endtask

  // Reference model over the bins recorded since the last accepted sop.
  task automatic push_expected();
    rec_t x;
    longint acc [NB];
    longint mag, pk;
    int pb;
    pk = 0;
    pb = 0;
    for (int b = 0; b < NB; b++) acc[b] = 0;
    for (int i = 0; i < re_m.size(); i++) begin
      mag = re_m[i] * re_m[i] + im_m[i] * im_m[i];
      if (mag > pk) begin
        pk = mag;
        pb = i;
      end
      for (int b = 0; b < NB; b++) begin
        if (i >= edge_m[b] && i < edge_m[b+1]) begin
          acc[b] += mag;
          break;
        end
      end
    end
    for (int b = 0; b < NB; b++) x.e[b] = ACC_W'(acc[b]);
    x.pbin = BIN_W'(pb);
    x.pmag = MAG_W'(pk);
    x.cyc  = 32'(last_cyc + 4);
    sb.push_back(x);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs_q.size() >= n) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (band_energy !== '0) begin
      errors++;
      $display("FAIL reset band_energy: got %h expected 0", band_energy);
    end
    checks++;
    if (energy_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset pulses: energy_valid=%b frame_err=%b expected 0/0", energy_valid, frame_err);
    end
  endtask

  task automatic test_basic();
    rec_t o, x;
    bit got;
    int e0;
    e0 = err_cnt;
    set_edges(0, 2, 4, 4, 4);
    bin(1'b1, 1'b0, 3, 4);
    bin(1'b0, 1'b0, 3, 4);
    band_edge = '1;
    bin(1'b0, 1'b0, 3, 4);
    bin(1'b0, 1'b1, 3, 4);
    x.e = {43'd0, 43'd0, 43'd50, 43'd50};
    x.cyc = 32'(last_cyc + 4);
    idle(1);
    wait_obs(1, 20, got);
    if (!got) begin
      checks++; errors++;
      $display("FAIL basic: no energy_valid within budget");
    end else begin
      o = obs_q.pop_front();
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (o.e[b] !== x.e[b]) begin
          errors++;
          $display("FAIL basic band%0d: got %0d expected %0d", b, o.e[b], x.e[b]);
        end
      end
      checks++;
      if (o.cyc !== x.cyc) begin
        errors++;
        $display("FAIL basic latency: energy_valid at cycle %0d expected %0d", o.cyc, x.cyc);
      end
    end
    idle(3);
    checks++;
    if (err_cnt !== e0 || obs_q.size() !== 0) begin
      errors++;
      $display("FAIL basic extra pulses: frame_err %0d extra results %0d expected 0/0", err_cnt - e0, obs_q.size());
    end
  endtask

  task automatic test_extremes();
    rec_t o;
    bit got;
    int e0;
    e0 = err_cnt;
    set_edges(0, 1, 1, 1, 1);
    bin(1'b1, 1'b1, -32768, -32768);
    idle(1);
    wait_obs(1, 20, got);
    if (!got) begin
      checks++; errors++;
      $display("FAIL extremes: no energy_valid within budget");
    end else begin
      o = obs_q.pop_front();
      checks++;
      if (o.e[0] !== 43'd2147483648 || o.e[1] !== '0 || o.e[2] !== '0 || o.e[3] !== '0) begin
        errors++;
        $display("FAIL extremes bands: got %0d/%0d/%0d/%0d expected 2147483648/0/0/0", o.e[0], o.e[1], o.e[2], o.e[3]);
      end
    end
    checks++;
    if (err_cnt !== e0) begin
      errors++;
      $display("FAIL extremes frame_err: got %0d pulses expected 0", err_cnt - e0);
    end
  endtask

  task automatic test_second_sop();
    rec_t o, x;
    bit got;
    int e0, sop2;
    e0 = err_cnt;
    set_edges(0, 3, 6, 9, 12);
    for (int i = 0; i < 5; i++) bin(i == 0, 1'b0, 100 + i, 50);
    bin(1'b1, 1'b0, 10, 0);
    sop2 = last_cyc;
    for (int k = 1; k < 5; k++) bin(1'b0, k == 4, 10 + k, -k);
    push_expected();
    idle(1);
    wait_obs(1, 20, got);
    checks++;
    if (err_cnt !== e0 + 1 || err_cyc !== sop2 + 1) begin
      errors++;
      $display("FAIL second_sop frame_err: pulses %0d at %0d expected 1 at %0d", err_cnt - e0, err_cyc, sop2 + 1);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL second_sop: no energy_valid within budget");
    end else begin
      o = obs_q.pop_front();
      x = sb.pop_front();
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (o.e[b] !== x.e[b]) begin
          errors++;
          $display("FAIL second_sop band%0d: got %0d expected %0d", b, o.e[b], x.e[b]);
        end
      end
    end
  endtask

  task automatic test_no_eop();
    rec_t o, x;
    bit got;
    int e0;
    e0 = err_cnt;
    set_edges(0, 256, 512, 768, 1023);
    for (int i = 0; i < NFFT; i++) bin(i == 0, 1'b0, 1, 0);
    push_expected();
    idle(1);
    wait_obs(1, 20, got);
    checks++;
    if (err_cnt !== e0 + 1 || err_cyc !== last_cyc + 1) begin
      errors++;
      $display("FAIL no_eop frame_err: pulses %0d at %0d expected 1 at %0d", err_cnt - e0, err_cyc, last_cyc + 1);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL no_eop: no energy_valid within budget");
    end else begin
      o = obs_q.pop_front();
      x = sb.pop_front();
      checks++;
      if (o.e !== {43'd255, 43'd256, 43'd256, 43'd256} || o.e !== x.e) begin
        errors++;
        $display("FAIL no_eop bands: got %0d/%0d/%0d/%0d expected 256/256/256/255", o.e[0], o.e[1], o.e[2], o.e[3]);
      end
      checks++;
      if (o.cyc !== x.cyc) begin
        errors++;
        $display("FAIL no_eop latency: energy_valid at %0d expected %0d", o.cyc, x.cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t o, x;
    bit got;
    int c;
    set_edges(0, 1, 2, 3, 4);
    bin(1'b1, 1'b0, 1, 2);
    bin(1'b0, 1'b0, 3, 0);
    bin(1'b0, 1'b1, 2, 2);
    push_expected();
    c = last_cyc;
    idle(3);
    drive(1'b1, 1'b1, 1'b1, 999, 999);
    if (cyc !== c + 4) $display("note: ignored-sop beat landed at offset %0d", cyc - c);
    bin(1'b1, 1'b0, 5, 5);
    bin(1'b0, 1'b1, 6, 0);
    push_expected();
    idle(1);
    wait_obs(2, 20, got);
    idle(8);
    checks++;
    if (!got || obs_q.size() !== 2) begin
      errors++;
      $display("FAIL back_to_back result count: got %0d expected 2", obs_q.size());
    end
    while (obs_q.size() > 0 && sb.size() > 0) begin
      o = obs_q.pop_front();
      x = sb.pop_front();
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (o.e[b] !== x.e[b]) begin
          errors++;
          $display("FAIL back_to_back band%0d: got %0d expected %0d", b, o.e[b], x.e[b]);
        end
      end
      checks++;
      if (o.cyc !== x.cyc) begin
        errors++;
        $display("FAIL back_to_back latency: got %0d expected %0d", o.cyc, x.cyc);
      end
    end
    obs_q.delete();
    sb.delete();
  endtask

  task automatic test_reset_mid();
    rec_t o, x;
    bit got;
    set_edges(0, 4, 8, 12, 16);
    for (int i = 0; i < 10; i++) bin(i == 0, 1'b0, 7, 7);
    bin(1'b0, 1'b0, 7, 7);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(10);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid energy_valid: got %0d results expected 0", obs_q.size());
      obs_q.delete();
    end
    checks++;
    if (band_energy !== '0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid outputs: band_energy %h frame_err %b expected 0/0", band_energy, frame_err);
    end
    set_edges(0, 1, 2, 3, 4);
    for (int i = 0; i < 5; i++) bin(i == 0, i == 4, i + 1, 1);
    push_expected();
    idle(1);
    wait_obs(1, 20, got);
    if (!got) begin
      checks++; errors++;
      $display("FAIL reset_mid clean frame: no energy_valid within budget");
    end else begin
      o = obs_q.pop_front();
      x = sb.pop_front();
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (o.e[b] !== x.e[b]) begin
          errors++;
          $display("FAIL reset_mid band%0d: got %0d expected %0d", b, o.e[b], x.e[b]);
        end
      end
    end
  endtask

  task automatic test_random();
    rec_t o, x;
    bit got;
    int len;
    for (int f = 0; f < 6; f++) begin
      set_edges($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(4, 16),
                $urandom_range(0, 20), $urandom_range(10, 24));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++)
        bin(i == 0, i == len - 1, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
      push_expected();
      idle(1);
      wait_obs(1, 20, got);
      if (!got) begin
        checks++; errors++;
        $display("FAIL random frame%0d: no energy_valid within budget", f);
      end else begin
        o = obs_q.pop_front();
        x = sb.pop_front();
        for (int b = 0; b < NB; b++) begin
          checks++;
          if (o.e[b] !== x.e[b]) begin
            errors++;
            $display("FAIL random frame%0d band%0d: got %0d expected %0d", f, b, o.e[b], x.e[b]);
          end
        end
`ifdef FFT_BAND_PEAK_EN
        checks++;
        if (o.pbin !== x.pbin || o.pmag !== x.pmag) begin
          errors++;
          $display("FAIL random frame%0d peak: got bin %0d mag %0d expected bin %0d mag %0d", f, o.pbin, o.pmag, x.pbin, x.pmag);
        end
`endif
      end
      idle(1);
    end
  endtask

`ifdef FFT_BAND_PEAK_EN
  task automatic test_peak();
    rec_t o;
    bit got;
    set_edges(0, 4, 4, 4, 4);
    bin(1'b1, 1'b0, 1, 0);
    bin(1'b0, 1'b0, 3, 0);
    bin(1'b0, 1'b0, 0, 3);
    bin(1'b0, 1'b1, 1, 1);
    idle(1);
    wait_obs(1, 20, got);
    if (!got) begin
      checks++; errors++;
      $display("FAIL peak: no energy_valid within budget");
    end else begin
      o = obs_q.pop_front();
      checks++;
      if (o.pbin !== 10'd1 || o.pmag !== 33'd9) begin
        errors++;
        $display("FAIL peak: got bin %0d mag %0d expected bin 1 mag 9", o.pbin, o.pmag);
      end
      checks++;
      if (o.e[0] !== 43'd21) begin
        errors++;
        $display("FAIL peak band0: got %0d expected 21", o.e[0]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_second_sop();
    test_no_eop();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef FFT_BAND_PEAK_EN
    test_peak();
`endif
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
